// File: rtl/fetch_pc_unit_if.sv
// ============================================================================
// Module : fetch_pc_unit_if
// Brief  : Instruction-memory request/response and fetch-to-decode bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_pc_unit_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_rsp_valid;
    logic [INSTR_WIDTH-1:0] imem_rsp_data;
    logic                   if_valid;
    logic                   if_ready;
    logic [INSTR_WIDTH-1:0] if_instr;
    logic [PC_WIDTH-1:0]    if_pc;

    modport master (
        output imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );
endinterface

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// Module : fetch_pc_unit
// Brief  : PC holder issuing one instruction fetch at a time, with branch/jump
//          redirect and wrong-path discard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_pc_unit #(
    parameter int                 PC_WIDTH    = 32,
    parameter int                 INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  wire                 clk,
    input  wire                 rst_n,
    input  wire                 pcsrc,
    input  wire  [PC_WIDTH-1:0] branch_target,
    input  wire                 jump,
    input  wire  [PC_WIDTH-1:0] jump_target,
    input  wire                 stall,
    fetch_pc_unit_if.master     bus
);

    localparam logic [PC_WIDTH-1:0] C_ALIGN_MASK = ~PC_WIDTH'(3);
    localparam logic [PC_WIDTH-1:0] C_PC_STEP    = PC_WIDTH'(4);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    req_pc_q, req_pc_d;
    logic                   drop_q, drop_d;
    logic                   if_valid_q, if_valid_d;
    logic [INSTR_WIDTH-1:0] if_instr_q, if_instr_d;
    logic [PC_WIDTH-1:0]    if_pc_q, if_pc_d;

    logic                   w_redirect;
    logic [PC_WIDTH-1:0]    w_target;
    logic                   w_req_valid;
    logic [PC_WIDTH-1:0]    w_req_addr;

    // Branch has priority over jump when both fire in the same cycle.
    always_comb begin
        w_redirect = pcsrc || jump;
        w_target   = (pcsrc ? branch_target : jump_target) & C_ALIGN_MASK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            drop_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            drop_q     <= drop_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        drop_d      = drop_q;
        if_valid_d  = if_valid_q;
        if_instr_d  = if_instr_q;
        if_pc_d     = if_pc_q;
        w_req_valid = 1'b0;
        w_req_addr  = req_pc_q;

        case (state_q)
            S_REQ: begin
                // A redirect bypasses stall and is itself the address requested.
                w_req_valid = !stall || w_redirect;
                w_req_addr  = w_redirect ? w_target : pc_q;
                if (w_req_valid && bus.imem_req_ready) begin
                    req_pc_d = w_req_addr;
                    pc_d     = w_req_addr + C_PC_STEP;
                    state_d  = S_WAIT;
                end else if (w_redirect) begin
                    pc_d = w_target;
                end
            end
            S_WAIT: begin
                if (w_redirect) begin
                    pc_d = w_target;
                    if (bus.imem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (bus.imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        if_instr_d = bus.imem_rsp_data;
                        if_pc_d    = req_pc_q;
                        if_valid_d = 1'b1;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_redirect) begin
                    if_valid_d = 1'b0;
                    pc_d       = w_target;
                    state_d    = S_REQ;
                end else if (bus.if_ready) begin
                    if_valid_d = 1'b0;
                    state_d    = S_REQ;
                end
            end
            default: begin
                if_valid_d = 1'b0;
                state_d    = S_REQ;
            end
        endcase
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_addr      = w_req_addr;
    assign bus.if_valid       = if_valid_q;
    assign bus.if_instr       = if_instr_q;
    assign bus.if_pc          = if_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
// ============================================================================
// Module : tb_fetch_pc_unit
// Brief  : Self-checking bench for fetch_pc_unit with memory and reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_pc_unit;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        pcsrc = 1'b0;
    logic        jump  = 1'b0;
    logic [31:0] bt    = '0;
    logic [31:0] jt    = '0;

    fetch_pc_unit_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    fetch_pc_unit #(
        .PC_WIDTH   (32),
        .INSTR_WIDTH(32),
        .RESET_PC   (32'h0000_0100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pcsrc        (pcsrc),
        .branch_target(bt),
        .jump         (jump),
        .jump_target  (jt),
        .stall        (stall),
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: fetch unit seen as "busy waiting" / "holding an instruction".
    bit          m_wait, m_hold, m_drop;
    logic [31:0] m_pc, m_req_pc, m_if_pc, m_instr;

    // Memory model: at most one pending response, fixed or random latency.
    bit          mem_pend = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_a    = '0;
    int          mem_lat  = 1;
    bit          lat_rand = 1'b0;

    logic [31:0] acc_q[$];
    logic [31:0] del_q[$];

    typedef struct {
        logic        stall;
        logic        pcsrc;
        logic        jump;
        logic        ready;
        logic [31:0] bt;
        logic [31:0] jt;
        logic        exp_valid;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] m_target();
        return pcsrc ? (bt & ~32'h3) : (jt & ~32'h3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wait   = 1'b0;
        m_hold   = 1'b0;
        m_drop   = 1'b0;
        m_pc     = 32'h0000_0100;
        m_req_pc = '0;
        m_if_pc  = '0;
        m_instr  = '0;
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic step();
        bit          redir, ev;
        logic [31:0] tg, ea;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = $urandom;
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = memf(mem_a);
                mem_pend           = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        #1;
        redir = pcsrc || jump;
        tg    = m_target();
        ev    = !m_wait && !m_hold && (!stall || redir);
        ea    = redir ? tg : m_pc;
        chk("req_valid", 32'(bus.imem_req_valid), 32'(ev));
        if (ev) chk("imem_addr", bus.imem_addr, ea);
        chk("if_valid", 32'(bus.if_valid), 32'(m_hold));
        chk("if_pc", bus.if_pc, m_if_pc);
        chk("if_instr", bus.if_instr, m_instr);

        if (bus.if_valid && bus.if_ready) del_q.push_back(bus.if_pc);
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            acc_q.push_back(bus.imem_addr);
            mem_pend = 1'b1;
            mem_a    = bus.imem_addr;
            mem_cnt  = (lat_rand ? int'($urandom_range(1, 3)) : mem_lat) - 1;
        end

        if (!rst_n) begin
            model_reset();
        end else if (!m_wait && !m_hold) begin
            if (ev && bus.imem_req_ready) begin
                m_req_pc = ea;
                m_pc     = ea + 32'd4;
                m_wait   = 1'b1;
            end else if (redir) begin
                m_pc = tg;
            end
        end else if (m_wait) begin
            if (redir) begin
                m_pc = tg;
                if (bus.imem_rsp_valid) begin
                    m_drop = 1'b0;
                    m_wait = 1'b0;
                end else begin
                    m_drop = 1'b1;
                end
            end else if (bus.imem_rsp_valid) begin
                m_wait = 1'b0;
                if (m_drop) begin
                    m_drop = 1'b0;
                end else begin
                    m_if_pc = m_req_pc;
                    m_instr = bus.imem_rsp_data;
                    m_hold  = 1'b1;
                end
            end
        end else begin
            if (redir) begin
                m_pc   = tg;
                m_hold = 1'b0;
            end else if (bus.if_ready) begin
                m_hold = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        //           stall pcsrc jump ready bt            jt            valid addr
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0000_010C};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0000_010C};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h0000_010C};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h203,      32'h0,        1'b1, 32'h0000_0200};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0000_0200};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h40B,      1'b1, 32'h0000_0408};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h80,       32'h90,       1'b1, 32'h0000_0080};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'hFFFFFFFD, 1'b1, 32'hFFFF_FFFC};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        1'b1, 32'hFFFF_FFFC};

        bus.imem_req_ready = 1'b0;
        bus.if_ready       = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_if_pc", bus.if_pc, 32'd0);
        chk("rst_if_instr", bus.if_instr, 32'd0);
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("rst_addr", bus.imem_addr, 32'h100);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch, 1-cycle memory, decode always ready
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b1;
        mem_lat            = 1;
        repeat (9) step();
        chk("seq_count", acc_q.size(), 32'd3);
        chk("seq_del_count", del_q.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("seq_addr", (i < acc_q.size()) ? acc_q[i] : 32'hDEAD_DEAD, 32'h100 + 32'(4 * i));
            chk("seq_if_pc", (i < del_q.size()) ? del_q[i] : 32'hDEAD_DEAD, 32'h100 + 32'(4 * i));
        end

        // Table of single-cycle REQ vectors (stall, redirect, priority, alignment)
        mem_lat = 3;
        for (int i = 0; i < 9; i++) begin
            stall              = tbl[i].stall;
            pcsrc              = tbl[i].pcsrc;
            jump               = tbl[i].jump;
            bt                 = tbl[i].bt;
            jt                 = tbl[i].jt;
            bus.imem_req_ready = tbl[i].ready;
            #1;
            chk("tbl_valid", 32'(bus.imem_req_valid), 32'(tbl[i].exp_valid));
            chk("tbl_addr", bus.imem_addr, tbl[i].exp_addr);
            step();
        end

        // Branch while waiting: response for 0xFFFFFFFC is dropped
        stall              = 1'b0;
        jump               = 1'b0;
        pcsrc              = 1'b1;
        bt                 = 32'h203;
        bus.imem_req_ready = 1'b1;
        mem_lat            = 1;
        step();
        pcsrc = 1'b0;
        repeat (2) step();
        #1;
        chk("drop_no_valid", 32'(bus.if_valid), 32'd0);
        chk("drop_next_addr", bus.imem_addr, 32'h200);
        repeat (2) step();
        chk("branch_if_pc", bus.if_pc, 32'h200);
        chk("branch_if_instr", bus.if_instr, memf(32'h200));

        // Jump kills the held instruction, then fetch wraps past 0xFFFFFFFC
        bus.if_ready = 1'b0;
        jump         = 1'b1;
        jt           = 32'hFFFF_FFFC;
        step();
        jump = 1'b0;
        #1;
        chk("hold_kill", 32'(bus.if_valid), 32'd0);
        repeat (2) step();
        for (int i = 0; i < 5; i++) begin
            chk("hold_if_pc", bus.if_pc, 32'hFFFF_FFFC);
            chk("hold_no_req", 32'(bus.imem_req_valid), 32'd0);
            step();
        end
        bus.if_ready = 1'b1;
        step();
        #1;
        chk("wrap_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("wrap_addr", bus.imem_addr, 32'h0);

        // Reset while waiting; the late response must be ignored
        mem_lat = 4;
        step();
        rst_n              = 1'b0;
        bus.imem_req_ready = 1'b0;
        model_reset();
        #1;
        chk("async_rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("async_rst_if_pc", bus.if_pc, 32'd0);
        chk("async_rst_addr", bus.imem_addr, 32'h100);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("late_rsp_ignored", 32'(bus.if_valid), 32'd0);
        chk("after_rst_addr", bus.imem_addr, 32'h100);

        // Randomized traffic against the reference model
        lat_rand = 1'b1;
        del_q.delete();
        for (int n = 0; n < 800; n++) begin
            stall              = ($urandom_range(0, 9) < 3);
            pcsrc              = ($urandom_range(0, 19) == 0);
            jump               = ($urandom_range(0, 19) == 0);
            bt                 = $urandom;
            jt                 = $urandom;
            bus.imem_req_ready = ($urandom_range(0, 9) < 7);
            bus.if_ready       = ($urandom_range(0, 9) < 6);
            step();
        end
        total++;
        if (del_q.size() == 0) begin
            bad++;
            $display("FAIL rand_progress: got 0 deliveries expected >0");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
